// File: rtl/interrupt_arbiter.sv
// Interrupt arbiter: collects watchdog/io/user events into pending bits and hands
// one at a time to the core through a request/ack/done handshake with a post-handler holdoff.
module interrupt_arbiter #(
    parameter int                      OFFSET_WIDTH   = 12,
    parameter logic [OFFSET_WIDTH-1:0] VEC_WDOG       = OFFSET_WIDTH'(12'h010),
    parameter logic [OFFSET_WIDTH-1:0] VEC_IO         = OFFSET_WIDTH'(12'h020),
    parameter logic [OFFSET_WIDTH-1:0] VEC_USER       = OFFSET_WIDTH'(12'h030),
    parameter int                      HOLDOFF_CYCLES = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    src_watchdog,
    input  logic                    src_io,
    input  logic                    src_user,
    input  logic                    is_os,
    input  logic                    is_bios,
    input  logic                    irq_ack,
    input  logic                    irq_done,
    output logic                    irq_valid,
    output logic [OFFSET_WIDTH-1:0] irq_vector,
    output logic [1:0]              irq_source,
    output logic [2:0]              pending,
    output logic                    overrun
);

    localparam int CNT_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES);

    typedef enum logic [1:0] {IDLE, REQUEST, SERVICE, HOLDOFF} state_t;

    typedef struct packed {
        logic [1:0]              src;
        logic [OFFSET_WIDTH-1:0] vec;
    } grant_t;

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic             user_q;
    logic             user_armed;
    logic             user_rise;
    logic [2:0]       events;
    logic [2:0]       clr;
    grant_t           winner;

    // A user line already high out of reset must fall once before its edge counts.
    assign user_rise = src_user & ~user_q & user_armed;
    assign events    = {user_rise, src_io, src_watchdog};

    always_comb begin
        clr = 3'b000;
        if (state == REQUEST && irq_ack) begin
            case (irq_source)
                2'b01:   clr = 3'b001;
                2'b10:   clr = 3'b010;
                2'b11:   clr = 3'b100;
                default: clr = 3'b000;
            endcase
        end
    end

    always_comb begin
        winner.src = 2'b00;
        winner.vec = '0;
        if (pending[0]) begin
            winner.src = 2'b01;
            winner.vec = VEC_WDOG;
        end else if (pending[1]) begin
            winner.src = 2'b10;
            winner.vec = VEC_IO;
        end else if (pending[2]) begin
            winner.src = 2'b11;
            winner.vec = VEC_USER;
        end
    end

    // A new event beats the ack clear on the same edge, and is not an overrun.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending    <= 3'b000;
            overrun    <= 1'b0;
            user_q     <= 1'b0;
            user_armed <= 1'b0;
        end else begin
            pending <= (pending & ~clr) | events;
            if (|(events & pending & ~clr))
                overrun <= 1'b1;
            user_q <= src_user;
            if (!src_user)
                user_armed <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            irq_valid  <= 1'b0;
            irq_vector <= '0;
            irq_source <= 2'b00;
            hold_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pending && !is_os && !is_bios) begin
                        state      <= REQUEST;
                        irq_valid  <= 1'b1;
                        irq_source <= winner.src;
                        irq_vector <= winner.vec;
                    end
                end
                REQUEST: begin
                    if (irq_ack) begin
                        state     <= SERVICE;
                        irq_valid <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (irq_done) begin
                        irq_source <= 2'b00;
                        irq_vector <= '0;
                        if (HOLDOFF_CYCLES == 0) begin
                            state <= IDLE;
                        end else begin
                            state    <= HOLDOFF;
                            hold_cnt <= HOLD_LOAD;
                        end
                    end
                end
                HOLDOFF: begin
                    if (hold_cnt <= CNT_W'(1)) begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    irq_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
